// File: rtl/atm_user_driver.sv
// atm_user_driver: host-side transmitter that plays one card/PIN/amount transaction into the
// ATM controller and folds its status lines into a result record. Optional macro: ATM_DRV_TIMEOUT_EN.
module atm_user_driver #(
  parameter int DIGIT_GAP      = 1,
  parameter int PIN_WAIT       = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic [15:0] CMD_PIN,
  input  logic        CMD_TIPO,
  input  logic [31:0] CMD_MONTO,
  output logic        TARJETA_RECIBIDA,
  output logic [3:0]  DIGITO,
  output logic        DIGITO_STB,
  output logic        TIPO_TRANS,
  output logic [31:0] MONTO,
  output logic        MONTO_STB,
  input  logic        BALANCE_STB,
  input  logic        ENTREGAR_DINERO,
  input  logic        FONDOS_INSUFICIENTES,
  input  logic        PIN_INCORRECTO,
  input  logic        ADVERTENCIA,
  input  logic        BLOQUEO,
  input  logic [63:0] BALANCE_ACTUALIZADO,
  output logic        RES_VALID,
  output logic [2:0]  RES_CODE,
  output logic [63:0] RES_BALANCE,
  output logic        RES_DISPENSED,
  output logic [1:0]  RES_INTENTOS
);

  // One shared counter serves the digit gap, the PIN window and the balance timeout.
  localparam int MAX_A = (DIGIT_GAP > PIN_WAIT) ? DIGIT_GAP : PIN_WAIT;
  localparam int MAX_C = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int CW    = $clog2(MAX_C + 1);
  localparam logic [CW-1:0] GAP_END = CW'(DIGIT_GAP - 1);
  localparam logic [CW-1:0] WIN_END = CW'(PIN_WAIT - 1);
`ifdef ATM_DRV_TIMEOUT_EN
  localparam logic [CW-1:0] TO_END    = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    C_TIMEOUT = 3'd4;
`endif
  localparam logic [2:0] C_OK      = 3'd0;
  localparam logic [2:0] C_FONDOS  = 3'd1;
  localparam logic [2:0] C_PIN_BAD = 3'd2;
  localparam logic [2:0] C_BLOCKED = 3'd3;

  typedef enum logic [3:0] {
    S_IDLE, S_CARD, S_DIGIT, S_GAP, S_PIN_WIN, S_SETUP, S_WAIT_BAL, S_DONE, S_RETRY
  } state_t;

  state_t          r_state, w_nxt;
  logic [15:0]     r_pin;
  logic            r_tipo;
  logic [31:0]     r_monto;
  logic [1:0]      r_idx;
  logic [CW-1:0]   r_cnt;
  logic            r_pin_q, r_adv_q;
  logic            r_res_valid;
  logic [2:0]      r_res_code;
  logic [63:0]     r_res_bal;
  logic            r_res_disp;
  logic [1:0]      r_intentos;

  logic            w_fire, w_busy, w_hold, w_rej_edge;
  logic [1:0]      w_int_inc, w_int_nxt;
  logic            w_res_set, w_bal_cap, w_idx_inc, w_cnt_clr, w_cnt_inc;
  logic [2:0]      w_res_code;

  assign CMD_READY  = RESET && (r_state == S_IDLE || r_state == S_RETRY);
  assign w_fire     = CMD_VALID && CMD_READY;
  assign w_busy     = (r_state == S_CARD) || (r_state == S_DIGIT) || (r_state == S_GAP) ||
                      (r_state == S_PIN_WIN) || (r_state == S_SETUP) || (r_state == S_WAIT_BAL);
  assign w_hold     = (r_state != S_IDLE) && (r_state != S_RETRY);
  assign w_rej_edge = (PIN_INCORRECTO && !r_pin_q) || (ADVERTENCIA && !r_adv_q);
  assign w_int_inc  = r_intentos + 2'd1;

  assign TIPO_TRANS    = w_hold ? r_tipo  : 1'b0;
  assign MONTO         = w_hold ? r_monto : 32'd0;
  assign RES_VALID     = r_res_valid;
  assign RES_CODE      = r_res_code;
  assign RES_BALANCE   = r_res_bal;
  assign RES_DISPENSED = r_res_disp;
  assign RES_INTENTOS  = r_intentos;

  always_ff @(posedge CLK) begin
    if (!RESET) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt            = r_state;
    w_res_set        = 1'b0;
    w_res_code       = C_OK;
    w_int_nxt        = r_intentos;
    w_bal_cap        = 1'b0;
    w_idx_inc        = 1'b0;
    w_cnt_clr        = 1'b0;
    w_cnt_inc        = 1'b0;
    TARJETA_RECIBIDA = 1'b0;
    DIGITO           = 4'd0;
    DIGITO_STB       = 1'b0;
    MONTO_STB        = 1'b0;
    case (r_state)
      S_IDLE:  if (w_fire) w_nxt = S_CARD;
      S_CARD: begin
        TARJETA_RECIBIDA = 1'b1;
        w_nxt            = S_DIGIT;
      end
      S_DIGIT: begin
        DIGITO     = r_pin[{~r_idx, 2'b00} +: 4];
        DIGITO_STB = 1'b1;
        w_cnt_clr  = 1'b1;
        if (r_idx == 2'd3) begin
          w_nxt = S_PIN_WIN;
        end else begin
          w_idx_inc = 1'b1;
          w_nxt     = (DIGIT_GAP == 0) ? S_DIGIT : S_GAP;
        end
      end
      S_GAP: begin
        if (r_cnt == GAP_END) w_nxt = S_DIGIT;
        else                  w_cnt_inc = 1'b1;
      end
      S_PIN_WIN: begin
        // A fresh rise of either verdict line inside the window counts as one reject.
        if (w_rej_edge) begin
          w_res_set = 1'b1;
          if (w_int_inc == 2'd3) begin
            w_res_code = C_BLOCKED;
            w_int_nxt  = 2'd0;
            w_nxt      = S_IDLE;
          end else begin
            w_res_code = C_PIN_BAD;
            w_int_nxt  = w_int_inc;
            w_nxt      = S_RETRY;
          end
        end else if (r_cnt == WIN_END) begin
          w_nxt = S_SETUP;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_SETUP: begin
        w_cnt_clr = 1'b1;
        w_nxt     = S_WAIT_BAL;
      end
      S_WAIT_BAL: begin
        MONTO_STB = 1'b1;
        if (BALANCE_STB) begin
          w_res_set  = 1'b1;
          w_bal_cap  = 1'b1;
          w_res_code = FONDOS_INSUFICIENTES ? C_FONDOS : C_OK;
          w_nxt      = S_DONE;
        end
`ifdef ATM_DRV_TIMEOUT_EN
        else if (r_cnt == TO_END) begin
          w_res_set  = 1'b1;
          w_res_code = C_TIMEOUT;
          w_int_nxt  = 2'd0;
          w_nxt      = S_IDLE;
        end else begin
          w_cnt_inc = 1'b1;
        end
`endif
      end
      S_DONE: begin
        w_int_nxt = 2'd0;
        w_nxt     = S_IDLE;
      end
      S_RETRY: if (w_fire) w_nxt = S_DIGIT;
      default: w_nxt = S_IDLE;
    endcase
    // Lockout from the controller wins over every in-flight step, including a same-cycle reject.
    if (BLOQUEO && w_busy) begin
      w_nxt      = S_IDLE;
      w_res_set  = 1'b1;
      w_res_code = C_BLOCKED;
      w_int_nxt  = 2'd0;
      w_bal_cap  = 1'b0;
      w_idx_inc  = 1'b0;
      w_cnt_clr  = 1'b0;
      w_cnt_inc  = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_pin       <= '0;
      r_tipo      <= 1'b0;
      r_monto     <= '0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_pin_q     <= 1'b0;
      r_adv_q     <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_code  <= '0;
      r_res_bal   <= '0;
      r_res_disp  <= 1'b0;
      r_intentos  <= '0;
    end else begin
      r_pin_q     <= PIN_INCORRECTO;
      r_adv_q     <= ADVERTENCIA;
      r_res_valid <= w_res_set;
      r_intentos  <= w_int_nxt;
      if (w_fire) begin
        r_pin   <= CMD_PIN;
        r_tipo  <= CMD_TIPO;
        r_monto <= CMD_MONTO;
        r_idx   <= '0;
      end else if (w_idx_inc) begin
        r_idx <= r_idx + 2'd1;
      end
      if (w_cnt_clr)      r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + 1'b1;
      if (w_res_set) begin
        r_res_code <= w_res_code;
        r_res_disp <= w_bal_cap ? ENTREGAR_DINERO : 1'b0;
        if (w_bal_cap) r_res_bal <= BALANCE_ACTUALIZADO;
      end
    end
  end

endmodule

// File: tb/tb_atm_user_driver.sv
// Directed bench for atm_user_driver with a small ATM-controller model; DIGIT_GAP 1, PIN_WAIT 4.
module tb_atm_user_driver;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_tipo = 1'b0;
  logic [15:0] cmd_pin = '0;
  logic [31:0] cmd_monto = '0;
  logic        adv = 1'b0, bloqueo = 1'b0;
  logic        bal_stb, entregar, fondos, pin_inc;
  logic [63:0] bal_bus;
  logic        cmd_ready, tarjeta, digito_stb, tipo_trans, monto_stb, res_valid, res_disp;
  logic [3:0]  digito;
  logic [31:0] monto;
  logic [2:0]  res_code;
  logic [63:0] res_bal;
  logic [1:0]  res_int;

  int nvec = 0, nfail = 0, fire_cyc = 0;
  logic        ctl_en = 1'b1, bal_req = 1'b0;
  logic [63:0] bal_val = '0;
  int          cyc, m_cards, m_card_cyc, m_ndig, m_nres, m_rej;
  int          m_dig_cyc[4];
  logic [15:0] m_pin;
  logic [63:0] m_bal;

  atm_user_driver #(.DIGIT_GAP(1), .PIN_WAIT(4), .TIMEOUT_CYCLES(8)) dut (
    .CLK(clk), .RESET(rst_n), .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_PIN(cmd_pin),
    .CMD_TIPO(cmd_tipo), .CMD_MONTO(cmd_monto), .TARJETA_RECIBIDA(tarjeta), .DIGITO(digito),
    .DIGITO_STB(digito_stb), .TIPO_TRANS(tipo_trans), .MONTO(monto), .MONTO_STB(monto_stb),
    .BALANCE_STB(bal_stb), .ENTREGAR_DINERO(entregar), .FONDOS_INSUFICIENTES(fondos),
    .PIN_INCORRECTO(pin_inc), .ADVERTENCIA(adv), .BLOQUEO(bloqueo), .BALANCE_ACTUALIZADO(bal_bus),
    .RES_VALID(res_valid), .RES_CODE(res_code), .RES_BALANCE(res_bal), .RES_DISPENSED(res_disp),
    .RES_INTENTOS(res_int));

  always #5 clk = ~clk;

  // Controller model: correct PIN is 0x1234, answers the amount strobe one cycle later.
  initial begin
    cyc = 0; m_cards = 0; m_card_cyc = 0; m_ndig = 0; m_nres = 0; m_rej = 0;
    m_pin = '0; m_bal = 64'd1000;
    bal_stb = 1'b0; entregar = 1'b0; fondos = 1'b0; pin_inc = 1'b0; bal_bus = '0;
    for (int i = 0; i < 4; i++) m_dig_cyc[i] = 0;
    forever begin
      @(negedge clk);
      cyc = cyc + 1;
      if (m_rej == 2) begin pin_inc = 1'b1; m_rej = 1; end
      else if (m_rej == 1) begin pin_inc = 1'b0; m_rej = 0; end
      if (bal_req) m_bal = bal_val;
      if (tarjeta) begin m_cards = m_cards + 1; m_card_cyc = cyc; m_ndig = 0; end
      if (digito_stb) begin
        if (m_ndig == 4) m_ndig = 0;
        m_pin = {m_pin[11:0], digito};
        m_dig_cyc[m_ndig] = cyc;
        m_ndig = m_ndig + 1;
        if (m_ndig == 4 && m_pin != 16'h1234) m_rej = 2;
      end
      if (bal_stb) begin
        bal_stb = 1'b0; entregar = 1'b0; fondos = 1'b0;
      end else if (monto_stb && ctl_en) begin
        if (!tipo_trans) m_bal = m_bal + {32'd0, monto};
        else if ({32'd0, monto} <= m_bal) begin m_bal = m_bal - {32'd0, monto}; entregar = 1'b1; end
        else fondos = 1'b1;
        bal_bus = m_bal;
        bal_stb = 1'b1;
      end
      if (res_valid) m_nres = m_nres + 1;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic load_bal(input logic [63:0] v);
    bal_val = v; bal_req = 1'b1; step(); bal_req = 1'b0;
  endtask

  task automatic send(input logic [15:0] pin, input logic tipo, input logic [31:0] amt, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (cmd_ready) begin ok = 1'b1; break; end
      step();
    end
    if (ok) begin
      cmd_pin = pin; cmd_tipo = tipo; cmd_monto = amt; cmd_valid = 1'b1; fire_cyc = cyc;
      step();
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_res(input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (res_valid) begin ok = 1'b1; break; end
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; step(); step();
    nvec++; if (cmd_ready !== 1'b0) begin nfail++; $display("FAIL rst_ready got %b want 0", cmd_ready); end
    nvec++; if ({tarjeta, digito_stb, digito, monto_stb, tipo_trans, res_valid, res_disp} !== 10'd0) begin
      nfail++; $display("FAIL rst_strobes got %b want 0", {tarjeta, digito_stb, digito, monto_stb, tipo_trans, res_valid, res_disp}); end
    nvec++; if (monto !== 32'd0) begin nfail++; $display("FAIL rst_monto got %0d want 0", monto); end
    nvec++; if ({res_code, res_int} !== 5'd0) begin nfail++; $display("FAIL rst_code_int got %b want 0", {res_code, res_int}); end
    nvec++; if (res_bal !== 64'd0) begin nfail++; $display("FAIL rst_bal got %0d want 0", res_bal); end
    rst_n = 1'b1; step();
    nvec++; if (cmd_ready !== 1'b1) begin nfail++; $display("FAIL rst_ready_after got %b want 1", cmd_ready); end
  endtask

  task automatic test_deposit();
    logic ok; int cards0;
    load_bal(64'd1000);
    cards0 = m_cards;
    send(16'h1234, 1'b0, 32'd500, ok);
    // A command offered mid-transaction must be ignored.
    cmd_pin = 16'h9999; cmd_valid = 1'b1; step(); step(); step(); cmd_valid = 1'b0;
    if (ok) wait_res(60, ok);
    nvec++; if (ok !== 1'b1) begin nfail++; $display("FAIL dep_result got %b want 1", ok); end
    nvec++; if (m_pin !== 16'h1234) begin nfail++; $display("FAIL dep_digits got %h want 1234", m_pin); end
    nvec++; if (m_cards !== cards0 + 1) begin nfail++; $display("FAIL dep_cards got %0d want %0d", m_cards, cards0 + 1); end
    nvec++; if (m_card_cyc !== fire_cyc + 1) begin nfail++; $display("FAIL dep_card_lat got %0d want %0d", m_card_cyc, fire_cyc + 1); end
    nvec++; if (m_dig_cyc[0] !== fire_cyc + 2) begin nfail++; $display("FAIL dep_dig0_lat got %0d want %0d", m_dig_cyc[0], fire_cyc + 2); end
    nvec++; if (m_dig_cyc[3] !== fire_cyc + 8) begin nfail++; $display("FAIL dep_dig3_lat got %0d want %0d", m_dig_cyc[3], fire_cyc + 8); end
    nvec++; if (res_code !== 3'd0) begin nfail++; $display("FAIL dep_code got %0d want 0", res_code); end
    nvec++; if (res_bal !== 64'd1500) begin nfail++; $display("FAIL dep_bal got %0d want 1500", res_bal); end
    nvec++; if ({res_disp, monto_stb} !== 2'b00) begin nfail++; $display("FAIL dep_disp_stb got %b want 00", {res_disp, monto_stb}); end
    step();
  endtask

  task automatic test_withdraw();
    logic ok;
    load_bal(64'd1000);
    send(16'h1234, 1'b1, 32'd300, ok);
    if (ok) wait_res(60, ok);
    nvec++; if (ok !== 1'b1) begin nfail++; $display("FAIL wd_result got %b want 1", ok); end
    nvec++; if (res_code !== 3'd0) begin nfail++; $display("FAIL wd_code got %0d want 0", res_code); end
    nvec++; if (res_bal !== 64'd700) begin nfail++; $display("FAIL wd_bal got %0d want 700", res_bal); end
    nvec++; if (res_disp !== 1'b1) begin nfail++; $display("FAIL wd_disp got %b want 1", res_disp); end
    step();
    send(16'h1234, 1'b1, 32'd2000, ok);
    if (ok) wait_res(60, ok);
    nvec++; if (ok !== 1'b1) begin nfail++; $display("FAIL wd2_result got %b want 1", ok); end
    nvec++; if (res_code !== 3'd1) begin nfail++; $display("FAIL wd2_code got %0d want 1", res_code); end
    nvec++; if (res_disp !== 1'b0) begin nfail++; $display("FAIL wd2_disp got %b want 0", res_disp); end
    nvec++; if (res_bal !== 64'd700) begin nfail++; $display("FAIL wd2_bal got %0d want 700", res_bal); end
    step();
  endtask

  task automatic test_retry();
    logic ok; int cards0;
    load_bal(64'd1000);
    send(16'h9999, 1'b0, 32'd100, ok);
    if (ok) wait_res(60, ok);
    nvec++; if ({ok, res_code} !== {1'b1, 3'd2}) begin nfail++; $display("FAIL rty_bad got %b want 1010", {ok, res_code}); end
    nvec++; if (res_int !== 2'd1) begin nfail++; $display("FAIL rty_int got %0d want 1", res_int); end
    cards0 = m_cards;
    send(16'h1234, 1'b0, 32'd100, ok);
    if (ok) wait_res(60, ok);
    nvec++; if ({ok, res_code} !== {1'b1, 3'd0}) begin nfail++; $display("FAIL rty_ok got %b want 1000", {ok, res_code}); end
    nvec++; if (m_cards !== cards0) begin nfail++; $display("FAIL rty_nocard got %0d want %0d", m_cards, cards0); end
    nvec++; if (m_dig_cyc[0] !== fire_cyc + 1) begin nfail++; $display("FAIL rty_dig0_lat got %0d want %0d", m_dig_cyc[0], fire_cyc + 1); end
    nvec++; if (res_bal !== 64'd1100) begin nfail++; $display("FAIL rty_bal got %0d want 1100", res_bal); end
    step();
    nvec++; if (res_int !== 2'd0) begin nfail++; $display("FAIL rty_int_clr got %0d want 0", res_int); end
  endtask

  task automatic test_three_bad();
    logic ok;
    for (int k = 0; k < 3; k++) begin
      send(16'h9999, 1'b0, 32'd50, ok);
      if (ok) wait_res(60, ok);
      nvec++; if (ok !== 1'b1) begin nfail++; $display("FAIL bad%0d_result got %b want 1", k, ok); end
      nvec++; if (res_code !== ((k == 2) ? 3'd3 : 3'd2)) begin nfail++; $display("FAIL bad%0d_code got %0d want %0d", k, res_code, (k == 2) ? 3 : 2); end
      nvec++; if (res_int !== ((k == 2) ? 2'd0 : 2'(k + 1))) begin nfail++; $display("FAIL bad%0d_int got %0d want %0d", k, res_int, (k == 2) ? 0 : k + 1); end
    end
    nvec++; if (cmd_ready !== 1'b1) begin nfail++; $display("FAIL bad_ready got %b want 1", cmd_ready); end
    step();
  endtask

  task automatic test_bloqueo();
    logic ok;
    ctl_en = 1'b0;
    send(16'h1234, 1'b0, 32'd10, ok);
    for (int i = 0; i < 40 && ok; i++) begin
      if (monto_stb) break;
      step();
    end
    nvec++; if (monto_stb !== 1'b1) begin nfail++; $display("FAIL blk_wait got %b want 1", monto_stb); end
    bloqueo = 1'b1; step(); bloqueo = 1'b0;
    nvec++; if ({res_valid, res_code} !== {1'b1, 3'd3}) begin nfail++; $display("FAIL blk_code got %b want 1011", {res_valid, res_code}); end
    nvec++; if ({monto_stb, cmd_ready} !== 2'b01) begin nfail++; $display("FAIL blk_idle got %b want 01", {monto_stb, cmd_ready}); end
    ctl_en = 1'b1;
    step();
  endtask

  task automatic test_reset_mid();
    logic ok; int nres0;
    load_bal(64'd1000);
    send(16'h1234, 1'b0, 32'd500, ok);
    for (int i = 0; i < 20 && ok; i++) begin
      if (m_ndig == 2) break;
      step();
    end
    nvec++; if (m_ndig !== 2) begin nfail++; $display("FAIL rmid_reach got %0d want 2", m_ndig); end
    nres0 = m_nres;
    rst_n = 1'b0; step();
    nvec++; if ({tarjeta, digito_stb, digito, monto_stb, tipo_trans, cmd_ready, res_valid} !== 10'd0) begin
      nfail++; $display("FAIL rmid_outs got %b want 0", {tarjeta, digito_stb, digito, monto_stb, tipo_trans, cmd_ready, res_valid}); end
    nvec++; if ({monto, res_bal} !== 96'd0) begin nfail++; $display("FAIL rmid_data got %0d/%0d want 0", monto, res_bal); end
    step(); rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step();
    nvec++; if (m_nres !== nres0) begin nfail++; $display("FAIL rmid_nores got %0d want %0d", m_nres, nres0); end
    load_bal(64'd1000);
    send(16'h1234, 1'b0, 32'd500, ok);
    if (ok) wait_res(60, ok);
    nvec++; if (m_card_cyc !== fire_cyc + 1) begin nfail++; $display("FAIL rmid_card got %0d want %0d", m_card_cyc, fire_cyc + 1); end
    nvec++; if ({ok, res_code} !== {1'b1, 3'd0}) begin nfail++; $display("FAIL rmid_code got %b want 1000", {ok, res_code}); end
    nvec++; if (res_bal !== 64'd1500) begin nfail++; $display("FAIL rmid_bal got %0d want 1500", res_bal); end
    step();
  endtask

`ifdef ATM_DRV_TIMEOUT_EN
  task automatic test_timeout();
    logic ok; int rise;
    ctl_en = 1'b0;
    send(16'h1234, 1'b0, 32'd10, ok);
    for (int i = 0; i < 40 && ok; i++) begin
      if (monto_stb) break;
      step();
    end
    rise = cyc;
    wait_res(40, ok);
    nvec++; if (ok !== 1'b1) begin nfail++; $display("FAIL to_result got %b want 1", ok); end
    nvec++; if (cyc - rise !== 8) begin nfail++; $display("FAIL to_lat got %0d want 8", cyc - rise); end
    nvec++; if ({res_code, monto_stb} !== {3'd4, 1'b0}) begin nfail++; $display("FAIL to_code got %b want 1000", {res_code, monto_stb}); end
    ctl_en = 1'b1;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_deposit();
    test_withdraw();
    test_retry();
    test_three_bad();
    test_bloqueo();
    test_reset_mid();
`ifdef ATM_DRV_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
